izh_neuron_array: RTL and testbench

IZH_NEURON_ARRAY -- requirements
Module: izh_neuron_array

---
 rtl/izh_neuron_array.sv | 149 ++++++++++++++
 tb/tb_izh_neuron_array.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/izh_neuron_array.sv
// Izhikevich neuron array: N neurons share one fixed-point integrator,
// stepped one neuron per cycle under a small IDLE/LOAD/UPDATE/DONE FSM.
module izh_neuron_array #(
  parameter int WIDTH     = 20,
  parameter int FR_WIDTH  = 11,
  parameter int N_NEURONS = 4,
  parameter int A_Q       = 41,
  parameter int B_Q       = 410,
  parameter int C004_Q    = 82,
  parameter int V_INIT    = -65,
  parameter int W_INIT    = -12,
  parameter int V_RESET   = -65,
  parameter int D_INC     = 8,
  parameter int V_PEAK    = 30,
  parameter int DT_SHIFT  = 0,
  localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          step_valid,
  output logic                          step_ready,
  input  logic [N_NEURONS*WIDTH-1:0]    syn_in,
  output logic [N_NEURONS-1:0]          spike_out,
  output logic                          done,
  input  logic [IW-1:0]                 probe_idx,
  output logic signed [WIDTH-1:0]       probe_v
);

  localparam int XW = 2*WIDTH + 34;

  localparam logic signed [XW-1:0] SMAX =
    {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = ~SMAX;

  localparam logic signed [XW-1:0] A_X    = XW'(A_Q);
  localparam logic signed [XW-1:0] B_X    = XW'(B_Q);
  localparam logic signed [XW-1:0] C004_X = XW'(C004_Q);
  localparam logic signed [XW-1:0] K140_X = XW'(140) <<< FR_WIDTH;
  localparam logic signed [XW-1:0] DINC_X = XW'(D_INC) <<< FR_WIDTH;

  localparam logic signed [WIDTH-1:0] VINI_W = WIDTH'(V_INIT <<< FR_WIDTH);
  localparam logic signed [WIDTH-1:0] WINI_W = WIDTH'(W_INIT <<< FR_WIDTH);
  localparam logic signed [WIDTH-1:0] VRST_W = WIDTH'(V_RESET <<< FR_WIDTH);
  localparam logic signed [WIDTH-1:0] VPK_W  = WIDTH'(V_PEAK <<< FR_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, UPDATE, DONE} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q;
  logic signed [WIDTH-1:0]  v_q   [N_NEURONS];
  logic signed [WIDTH-1:0]  w_q   [N_NEURONS];
  logic signed [WIDTH-1:0]  syn_q [N_NEURONS];
  logic [N_NEURONS-1:0]     fire_q;
  logic [N_NEURONS-1:0]     spike_q;
  logic signed [WIDTH-1:0]  probe_q;

  logic                     last;
  logic signed [WIDTH-1:0]  v_c, w_c, i_c;
  logic signed [XW-1:0]     vx, wx, ix, sq, dv, vn, bv, dw, wn;
  logic signed [WIDTH-1:0]  v_sat, w_sat, w_bump, v_upd, w_upd;
  logic                     fire;

  function automatic logic signed [WIDTH-1:0] sat(
    input logic signed [XW-1:0] x
  );
    if (x > SMAX)      sat = SMAX[WIDTH-1:0];
    else if (x < SMIN) sat = SMIN[WIDTH-1:0];
    else               sat = x[WIDTH-1:0];
  endfunction

  assign last       = (idx_q == IW'(N_NEURONS-1));
  assign step_ready = (state_q == IDLE);
  assign done       = (state_q == DONE);
  assign spike_out  = spike_q;
  assign probe_v    = probe_q;

  assign v_c = v_q[idx_q];
  assign w_c = w_q[idx_q];
  assign i_c = syn_q[idx_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (step_valid) state_d = LOAD;
      LOAD:    state_d = UPDATE;
      UPDATE:  if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Wide intermediates keep v*v and the coefficient products exact
  always_comb begin
    vx     = XW'(v_c);
    wx     = XW'(w_c);
    ix     = XW'(i_c);
    sq     = (vx * vx) >>> FR_WIDTH;
    dv     = ((C004_X * sq) >>> FR_WIDTH) + (vx <<< 2) + vx
             + K140_X - wx + ix;
    vn     = vx + (dv >>> DT_SHIFT);
    bv     = (B_X * vx) >>> FR_WIDTH;
    dw     = (A_X * (bv - wx)) >>> FR_WIDTH;
    wn     = wx + (dw >>> DT_SHIFT);
    v_sat  = sat(vn);
    w_sat  = sat(wn);
    fire   = (v_sat >= VPK_W);
    w_bump = sat(XW'(w_sat) + DINC_X);
    v_upd  = fire ? VRST_W : v_sat;
    w_upd  = fire ? w_bump : w_sat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fire_q  <= '0;
      spike_q <= '0;
      probe_q <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= VINI_W;
        w_q[i] <= WINI_W;
      end
    end else begin
      state_q <= state_d;
      probe_q <= (int'(probe_idx) < N_NEURONS) ? v_q[probe_idx] : '0;
      unique case (state_q)
        IDLE: begin
          if (step_valid) begin
            for (int i = 0; i < N_NEURONS; i++)
              syn_q[i] <= syn_in[i*WIDTH +: WIDTH];
          end
        end
        LOAD: begin
          idx_q  <= '0;
          fire_q <= '0;
        end
        UPDATE: begin
          v_q[idx_q]    <= v_upd;
          w_q[idx_q]    <= w_upd;
          fire_q[idx_q] <= fire;
          idx_q         <= idx_q + 1'b1;
        end
        DONE: spike_q <= fire_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_izh_neuron_array.sv
// Randomized scoreboard bench for izh_neuron_array against an
// arithmetic reference model of the Izhikevich update.
module tb_izh_neuron_array;

  localparam int N = 4;
  localparam int W = 20;
  localparam int F = 11;
  localparam longint S = longint'(1) <<< F;

  typedef struct packed {
    logic [N-1:0]   spk;
    logic [N*W-1:0] v;
    logic           chk_v;
    logic [31:0]    acc;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                step_valid;
  logic                step_ready;
  logic [N*W-1:0]      syn_in;
  logic [N-1:0]        spike_out;
  logic                done;
  logic [1:0]          probe_idx;
  logic signed [W-1:0] probe_v;

  izh_neuron_array dut (
    .clk        (clk),
    .reset      (reset),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .syn_in     (syn_in),
    .spike_out  (spike_out),
    .done       (done),
    .probe_idx  (probe_idx),
    .probe_v    (probe_v)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int push_cnt = 0;
  int mon_cnt = 0;
  int sweep_req = 0;
  int sweep_ack = 0;
  longint mv [N];
  longint mw [N];
  int mfire [N];
  int dfire [N];
  exp_t q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat_m(input longint x);
    longint hi = (longint'(1) <<< (W-1)) - 1;
    longint lo = -(longint'(1) <<< (W-1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // floor division by 2^k
  function automatic longint fdiv(input longint x, input int k);
    return x >>> k;
  endfunction

  task automatic model_rst();
    for (int i = 0; i < N; i++) begin
      mv[i] = -65 * S;
      mw[i] = -12 * S;
    end
  endtask

  function automatic exp_t model_step(input logic [N*W-1:0] syn,
                                      input int acc, input bit chk_v);
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      longint I, v, w, dv, vn, wn;
      I  = longint'($signed(syn[i*W +: W]));
      v  = mv[i];
      w  = mw[i];
      dv = fdiv(82 * fdiv(v * v, F), F) + 5 * v + 140 * S - w + I;
      vn = sat_m(v + dv);
      wn = sat_m(w + fdiv(41 * (fdiv(410 * v, F) - w), F));
      if (vn >= 30 * S) begin
        e.spk[i] = 1'b1;
        mfire[i]++;
        mv[i] = -65 * S;
        mw[i] = sat_m(wn + 8 * S);
      end else begin
        mv[i] = vn;
        mw[i] = wn;
      end
      e.v[i*W +: W] = mv[i][W-1:0];
    end
    e.chk_v = chk_v;
    e.acc   = acc;
    return e;
  endfunction

  function automatic logic [N*W-1:0] rnd_syn();
    logic [N*W-1:0] s;
    for (int i = 0; i < N; i++) begin
      int r = $urandom_range(0, 9);
      longint x;
      if (r == 0)      x = (longint'(1) <<< (W-1)) - 1;
      else if (r == 1) x = -(longint'(1) <<< (W-1));
      else             x = longint'($urandom_range(0, 60*2048)) - 20*2048;
      s[i*W +: W] = x[W-1:0];
    end
    return s;
  endfunction

  function automatic logic [N*W-1:0] one_syn(input int n, input longint x);
    logic [N*W-1:0] s = '0;
    s[n*W +: W] = x[W-1:0];
    return s;
  endfunction

  // Monitor: owns probe_idx; checks done events and probe sweeps
  initial begin
    exp_t e;
    probe_idx = '0;
    forever begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_latency", cyc - int'(e.acc), N + 1);
          chk("ready_during_done", step_ready, 0);
          @(posedge clk); #1;
          chk("spike_out", spike_out, e.spk);
          chk("done_one_cycle", done, 0);
          for (int i = 0; i < N; i++) dfire[i] += int'(spike_out[i]);
          if (e.chk_v) begin
            for (int k = 0; k < N; k++) begin
              @(negedge clk);
              probe_idx = 2'(k);
              @(negedge clk);
              chk($sformatf("v[%0d]", k), probe_v,
                  longint'($signed(e.v[k*W +: W])));
            end
          end
          mon_cnt++;
        end
      end else if (sweep_ack != sweep_req) begin
        chk("idle_ready", step_ready, 1);
        for (int k = 0; k < N; k++) begin
          probe_idx = 2'(k);
          @(negedge clk);
          chk($sformatf("sweep_v[%0d]", k), probe_v, mv[k]);
        end
        sweep_ack++;
      end
    end
  end

  task automatic wait_mon();
    int b = 0;
    while (mon_cnt != push_cnt && b < 300) begin
      @(negedge clk);
      b++;
    end
    chk("monitor_timeout", mon_cnt, push_cnt);
  endtask

  task automatic sweep();
    int b = 0;
    sweep_req++;
    while (sweep_ack != sweep_req && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk("sweep_timeout", sweep_ack, sweep_req);
  endtask

  task automatic do_step(input logic [N*W-1:0] syn, input bit chk_v,
                         input bit push);
    int b = 0;
    int acc;
    @(negedge clk);
    while (!step_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!step_ready) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    step_valid = 1'b1;
    syn_in = syn;
    @(posedge clk); #1;
    acc = cyc;
    step_valid = 1'b0;
    for (int i = 0; i < N; i++) syn_in[i*W +: W] = W'($urandom);
    if (push) begin
      q.push_back(model_step(syn, acc, chk_v));
      push_cnt++;
    end
  endtask

  initial begin
    int cnt, last, acc;
    logic [N*W-1:0] cur;
    reset = 1'b1;
    step_valid = 1'b0;
    syn_in = '0;
    for (int i = 0; i < N; i++) begin
      mfire[i] = 0;
      dfire[i] = 0;
    end
    model_rst();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_probe_v", probe_v, 0);
    chk("rst_spike", spike_out, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", step_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    sweep();

    // all-zero current step
    do_step('0, 1'b1, 1'b1);
    wait_mon();

    // strong drive on neuron 2
    for (int s = 0; s < 6; s++) begin
      do_step(one_syn(2, 200 * S), 1'b1, 1'b1);
      wait_mon();
    end
    for (int i = 0; i < N; i++)
      chk($sformatf("fire_cnt_drive[%0d]", i), dfire[i], mfire[i]);

    // saturating currents at both extremes
    for (int s = 0; s < 3; s++) begin
      cur = one_syn(1, (longint'(1) <<< (W-1)) - 1)
          | one_syn(3, -(longint'(1) <<< (W-1)));
      do_step(cur, 1'b1, 1'b1);
      wait_mon();
    end

    // randomized steps
    for (int s = 0; s < 20; s++) begin
      do_step(rnd_syn(), 1'b1, 1'b1);
      wait_mon();
    end

    // back-to-back acceptance with step_valid held high
    cnt = 0;
    last = -1;
    @(negedge clk);
    step_valid = 1'b1;
    syn_in = rnd_syn();
    for (int b = 0; b < 100; b++) begin
      if (cnt == 5) break;
      if (step_ready) begin
        cur = syn_in;
        @(posedge clk); #1;
        acc = cyc;
        q.push_back(model_step(cur, acc, 1'b0));
        push_cnt++;
        if (last >= 0) chk("b2b_interval", acc - last, N + 3);
        last = acc;
        cnt++;
        syn_in = rnd_syn();
      end
      @(negedge clk);
    end
    step_valid = 1'b0;
    chk("b2b_count", cnt, 5);
    wait_mon();
    sweep();

    // reset during UPDATE of idx 1 aborts the step
    do_step(rnd_syn(), 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_done", done, 0);
    chk("abort_spike", spike_out, 0);
    chk("abort_probe", probe_v, 0);
    @(negedge clk);
    reset = 1'b0;
    model_rst();
    repeat (12) @(negedge clk);
    sweep();

    // a few more steps from the freshly reset state
    for (int s = 0; s < 4; s++) begin
      do_step(rnd_syn(), 1'b1, 1'b1);
      wait_mon();
    end

    for (int i = 0; i < N; i++)
      chk($sformatf("fire_cnt[%0d]", i), dfire[i], mfire[i]);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
